// File: rtl/hazard_ctrl.sv
// Decode-stage hazard control: a per-register scoreboard raises stall_out on RAW/WAW hazards.
// Branch redirects flush fetch/decode for several cycles and squash wrong-path scoreboard entries.
module hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int YOUNG_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_write,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  redirect,
  output logic                  stall_out,
  output logic                  flush_out,
  output logic [NUM_REGS-1:0]   busy_mask
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                                   state, state_n;
  logic [3:0]                               cnt, cnt_n;
  logic                                     flush_n;
  logic [NUM_REGS-1:0]                      busy_n;
  logic [YOUNG_DEPTH-1:0]                   yv, yv_n;
  logic [YOUNG_DEPTH-1:0][REG_ADDR_W-1:0]   yrd, yrd_n;
  logic                                     hz_rs1, hz_rs2, hz_rd;
  logic                                     issue, sets_rd;

  // An operand conflicts only if its register is busy and not being written back this cycle.
  function automatic logic reg_hz(input logic [REG_ADDR_W-1:0] a, input logic used,
                                  input logic [NUM_REGS-1:0] busy,
                                  input logic wbv, input logic [REG_ADDR_W-1:0] wba);
    return used && busy[a] && (a != '0) && !(wbv && (wba == a));
  endfunction

  always_comb begin
    hz_rs1    = reg_hz(rs1_addr, rs1_used, busy_mask, wb_valid, wb_addr);
    hz_rs2    = reg_hz(rs2_addr, rs2_used, busy_mask, wb_valid, wb_addr);
    hz_rd     = reg_hz(rd_addr, rd_write, busy_mask, wb_valid, wb_addr);
    stall_out = !reset && dec_valid && (hz_rs1 || hz_rs2 || hz_rd);
    issue     = dec_valid && !stall_out && !flush_out && !redirect;
    sets_rd   = issue && rd_write && (rd_addr != '0);
  end

  // Next-state: scoreboard, young window, flush sequencer.
  always_comb begin
    busy_n  = busy_mask;
    yv_n    = yv;
    yrd_n   = yrd;
    state_n = state;
    cnt_n   = cnt;
    flush_n = flush_out;

    if (wb_valid) busy_n[wb_addr] = 1'b0;
    if (sets_rd)  busy_n[rd_addr] = 1'b1;
    if (redirect) begin
      for (int i = 0; i < YOUNG_DEPTH; i++)
        if (yv[i]) busy_n[yrd[i]] = 1'b0;
    end
    busy_n[0] = 1'b0;

    if (redirect) begin
      yv_n = '0;
    end else if (!stall_out) begin
      for (int i = YOUNG_DEPTH - 1; i >= 1; i--) begin
        yv_n[i]  = yv[i-1];
        yrd_n[i] = yrd[i-1];
      end
      yv_n[0]  = sets_rd;
      yrd_n[0] = rd_addr;
    end

    case (state)
      IDLE: begin
        if (redirect) begin
          state_n = FLUSH;
          cnt_n   = 4'(FLUSH_CYCLES - 1);
          flush_n = 1'b1;
        end
      end
      FLUSH: begin
        if (redirect) begin
          cnt_n = 4'(FLUSH_CYCLES - 1);
        end else if (cnt == 4'd0) begin
          state_n = IDLE;
          flush_n = 1'b0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        flush_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      flush_out <= 1'b0;
      busy_mask <= '0;
      yv        <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      flush_out <= flush_n;
      busy_mask <= busy_n;
      yv        <= yv_n;
    end
  end

  // Destination tags are qualified by yv, so they need no reset.
  always_ff @(posedge clk) begin
    yrd <= yrd_n;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl: per-vector combinational stall check plus a
// scoreboard queue of post-edge busy_mask/flush_out expectations.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset, dec_valid, rs1_used, rs2_used, rd_write, wb_valid, redirect;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_addr;
  logic        stall_out, flush_out;
  logic [31:0] busy_mask;

  int compared = 0;
  int mismatched = 0;

  hazard_ctrl #(.NUM_REGS(32), .REG_ADDR_W(5), .FLUSH_CYCLES(2), .YOUNG_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .rd_addr(rd_addr), .rd_write(rd_write), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .redirect(redirect), .stall_out(stall_out), .flush_out(flush_out), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, dv;
    logic [4:0]  rs1; logic u1;
    logic [4:0]  rs2; logic u2;
    logic [4:0]  rd;  logic w;
    logic        wbv; logic [4:0] wba;
    logic        redir;
    logic        e_stall, e_flush;
    logic [31:0] e_busy;
  } vec_t;

  typedef struct {
    int          idx;
    logic        flush;
    logic [31:0] busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic rst, input logic dv,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [4:0] rd, input logic w,
                              input logic wbv, input logic [4:0] wba, input logic redir,
                              input logic es, input logic ef, input logic [31:0] eb);
    vec_t v;
    v.rst = rst; v.dv = dv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.w = w; v.wbv = wbv; v.wba = wba; v.redir = redir;
    v.e_stall = es; v.e_flush = ef; v.e_busy = eb;
    return v;
  endfunction

  task automatic drive_idle();
    reset = 0; dec_valid = 0; rs1_addr = 0; rs1_used = 0; rs2_addr = 0; rs2_used = 0;
    rd_addr = 0; rd_write = 0; wb_valid = 0; wb_addr = 0; redirect = 0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst; dec_valid = v.dv; rs1_addr = v.rs1; rs1_used = v.u1;
    rs2_addr = v.rs2; rs2_used = v.u2; rd_addr = v.rd; rd_write = v.w;
    wb_valid = v.wbv; wb_addr = v.wba; redirect = v.redir;
    #1;
    compared++;
    if (stall_out !== v.e_stall) begin
      mismatched++;
      $display("FAIL stall vec%0d: got %b want %b", idx, stall_out, v.e_stall);
    end
    e.idx = idx; e.flush = v.e_flush; e.busy = v.e_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (busy_mask !== e.busy) begin
      mismatched++;
      $display("FAIL busy vec%0d: got %h want %h", e.idx, busy_mask, e.busy);
    end
    compared++;
    if (flush_out !== e.flush) begin
      mismatched++;
      $display("FAIL flush vec%0d: got %b want %b", e.idx, flush_out, e.flush);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hi_cnt;
    drive_idle();
    //           rst dv rs1 u1 rs2 u2 rd w wbv wba rdr  stall flush busy
    vecs.push_back(mk(1, 1, 5, 1, 0, 0, 5, 1, 0, 0, 0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 32'h20));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  1, 0, 32'h20));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  1, 0, 32'h20));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 1, 5, 0,  0, 0, 32'h40));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 32'h80));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  0, 0, 32'h80));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h80));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 32'h08));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 0, 32'h18));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 1,  0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 32'h1000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h1000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h1000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 32'h002));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0,  0, 0, 32'h102));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  0, 0, 32'h302));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1, 8, 1, 0, 0, 11, 1, 0, 0, 0, 1, 0, 32'h302));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h002));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Single redirect from idle: flush_out must stay high for exactly FLUSH_CYCLES cycles.
    @(negedge clk);
    drive_idle();
    redirect = 1;
    @(posedge clk);
    #1;
    redirect = 0;
    hi_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (flush_out) hi_cnt++;
      @(posedge clk);
      #1;
    end
    compared++;
    if (hi_cnt != 2) begin
      mismatched++;
      $display("FAIL flush_len: got %0d cycles want 2", hi_cnt);
    end

    // A source read of a busy register while a WAW-free dest is requested stalls via rs2 too.
    @(negedge clk);
    drive_idle();
    dec_valid = 1; rd_addr = 14; rd_write = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rd_addr = 15; rs2_addr = 14; rs2_used = 1;
    #1;
    compared++;
    if (stall_out !== 1'b1) begin
      mismatched++;
      $display("FAIL rs2_raw: got %b want 1", stall_out);
    end
    wb_valid = 1; wb_addr = 14;
    #1;
    compared++;
    if (stall_out !== 1'b0) begin
      mismatched++;
      $display("FAIL rs2_wb_release: got %b want 0", stall_out);
    end
    @(posedge clk);
    #1;
    compared++;
    if (busy_mask !== 32'h8000) begin
      mismatched++;
      $display("FAIL rs2_busy: got %h want %h", busy_mask, 32'h8000);
    end
    @(negedge clk);
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block for the decode stage. Owns a per-register scoreboard of pending writebacks and raises `stall` to decode when a source or destination register has an outstanding writer.
- Sequences multi-cycle `flush` on a branch redirect from execute and squashes scoreboard entries of wrong-path instructions.
- Sits beside decode and the register file. Drives the `stall`/`flush` inputs of fetch and decode.

Parameters:
- NUM_REGS, 32, architectural registers; reg 0 is hard-wired zero and never busy.
- REG_ADDR_W, 5, register address width (log2 NUM_REGS).
- FLUSH_CYCLES, 2, cycles `flush_out` is held after a redirect (1..15).
- YOUNG_DEPTH, 2, issue-window entries squashed on redirect (1..4).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- dec_valid  in  1  decode holds a valid instruction
- rs1_addr  in  REG_ADDR_W  source 1 index
- rs1_used  in  1  instruction reads rs1
- rs2_addr  in  REG_ADDR_W  source 2 index
- rs2_used  in  1  instruction reads rs2
- rd_addr  in  REG_ADDR_W  destination index
- rd_write  in  1  instruction writes rd
- wb_valid  in  1  writeback this cycle
- wb_addr  in  REG_ADDR_W  writeback destination
- redirect  in  1  execute resolved a taken branch/jump (1-cycle pulse)
- stall_out  out  1  hold fetch/decode (combinational)
- flush_out  out  1  invalidate fetch/decode (registered)
- busy_mask  out  NUM_REGS  scoreboard state (registered, debug/verification)

Behaviour:
- Reset: `busy_mask`=0, `flush_out`=0, flush counter=0, FSM=IDLE, all young-window entries invalid. `stall_out`=0 while reset is high.
- Hazard (combinational), per source: `hz_rsN = rsN_used & busy[rsN] & rsN!=0 & !(wb_valid & wb_addr==rsN)`. Same-cycle writeback releases the source because the regfile writes through.
- WAW: `hz_rd = rd_write & busy[rd] & rd!=0 & !(wb_valid & wb_addr==rd)`.
- `stall_out = dec_valid & (hz_rs1 | hz_rs2 | hz_rd)`.
- issue = `dec_valid & !stall_out & !flush_out & !redirect`.
- Scoreboard update each edge:
  - Clear `busy[wb_addr]` on `wb_valid`.
  - Set `busy[rd]` on issue & rd_write & rd!=0.
  - If set and clear hit the same register in one cycle, set wins.
  - A clear on a non-busy register is ignored.
  - Bit 0 is always 0.
- WAW stalling guarantees at most one pending writer per register.
- Young window: shift register of YOUNG_DEPTH entries {v, rd}.
  - Shifts when `stall_out`=0; inserts {issue & rd_write & rd!=0, rd_addr}.
  - Holds while stalled.
  - Flushes to all-invalid on redirect.
- Redirect: for every valid young entry, `busy[entry.rd]` is cleared at the same edge. This squash takes priority over the set; a same-cycle issue is already suppressed.
- Flush FSM:
  - IDLE→FLUSH on redirect; counter loads FLUSH_CYCLES-1 and `flush_out`=1 from the next cycle.
  - FLUSH: counter decrements each cycle; at 0 with no redirect, go to IDLE and `flush_out`=0.
  - Redirect during FLUSH reloads the counter (flush extends) and squashes the young window again.
  - Net effect: `flush_out` is high exactly FLUSH_CYCLES cycles after the last redirect.
- Writebacks continue during FLUSH and clear bits normally; older instructions are unaffected.
- Reset mid-FLUSH or with busy bits set: everything returns to reset values at that edge. Reset wins over every other input.
- wb_valid with wb_addr=0 is a no-op.

Test Plan:
- Reset, then issue `rd_write` rd=5 → next cycle `busy_mask`=0x20. Next instr with rs1=5, rs1_used → `stall_out`=1 until `wb_valid` wb_addr=5; `stall_out`=0 in the wb cycle; `busy_mask`=0 after.
- Same cycle: wb_addr=7 clears while issue sets rd=7 → `busy[7]`=1 (set wins). Instr with rd=7 while busy → `stall_out`=1 (WAW).
- rd=0 with rd_write and rs1=0 → never busy, never stalls; wb_addr=0 has no effect.
- Issue rd=3, then rd=4 (YOUNG_DEPTH=2), then redirect → `busy_mask`=0 next cycle; `flush_out`=1 for exactly 2 cycles; a dec_valid in the redirect cycle does not set a busy bit.
- Redirect, then a second redirect one cycle later → `flush_out` high 3 consecutive cycles. Assert reset mid-flush → `flush_out`=0, `busy_mask`=0 next cycle.
- Stall held 4 cycles with a busy source → young window unchanged. Redirect after the stall squashes only entries issued before the stall.
